// File: rtl/adsr_env_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// synth_pkg : shared envelope types, level width and rate-to-step helper
// Rev 1.0
// ----------------------------------------------------------------------------
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int              LEVEL_W   = 16;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 16'hFFFF;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // A zero rate means "instant": a full-scale step always reaches the bound.
    function automatic logic [LEVEL_W-1:0] rate_to_step(input logic [7:0] rate,
                                                        input int unsigned sh);
        logic [LEVEL_W-1:0] s;
        s = LEVEL_W'(rate) << sh;
        if (rate == 8'd0) begin
            s = LEVEL_MAX;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_env_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adsr_env_if : control, sample and status signals of the envelope block
// Rev 1.0
// ----------------------------------------------------------------------------
interface adsr_env_if;
    import synth_pkg::*;

    logic       en;
    logic       gate;
    logic       strobe;
    logic [7:0] attack_rate;
    logic [7:0] decay_rate;
    logic [7:0] sustain_lvl;
    logic [7:0] release_rate;
    logic [7:0] osc_sample;
    logic [7:0] sample;
    logic [7:0] env_level;
    env_state_t env_state;
    logic       active;

    modport master (
        output en, gate, strobe, attack_rate, decay_rate, sustain_lvl,
               release_rate, osc_sample,
        input  sample, env_level, env_state, active
    );

    modport slave (
        input  en, gate, strobe, attack_rate, decay_rate, sustain_lvl,
               release_rate, osc_sample,
        output sample, env_level, env_state, active
    );

endinterface
`default_nettype wire

// File: rtl/adsr_env_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// env_step : saturating level step toward LEVEL_MAX (up) or a floor (down)
// Rev 1.0
// ----------------------------------------------------------------------------
module env_step
    import synth_pkg::*;
(
    input  logic [LEVEL_W-1:0] level,
    input  logic [LEVEL_W-1:0] step,
    input  logic [LEVEL_W-1:0] floor,
    input  logic               dir,
    output logic [LEVEL_W-1:0] next_level,
    output logic               hit
);

    logic [LEVEL_W:0]   sum;
    logic [LEVEL_W-1:0] headroom;

    always_comb begin
        sum        = {1'b0, level} + {1'b0, step};
        headroom   = level - floor;
        next_level = level;
        hit        = 1'b0;
        if (dir == DIR_UP) begin
            if (sum >= {1'b0, LEVEL_MAX}) begin
                next_level = LEVEL_MAX;
                hit        = 1'b1;
            end else begin
                next_level = sum[LEVEL_W-1:0];
            end
        end else begin
            // headroom is only valid once level is known to be above floor
            if ((level <= floor) || (headroom <= step)) begin
                next_level = floor;
                hit        = 1'b1;
            end else begin
                next_level = level - step;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adsr_env.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adsr_env : gate-driven ADSR envelope scaling an oscillator sample per strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module adsr_env
    import synth_pkg::*;
#(
    parameter int unsigned STEP_SH = 4
)
(
    input  logic       clk,
    input  logic       rst,
    adsr_env_if.slave  bus
);

    env_state_t         state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [7:0]         sample_q, sample_d;
    logic [7:0]         env_level_q, env_level_d;

    logic [LEVEL_W-1:0] attack_step;
    logic [LEVEL_W-1:0] decay_step;
    logic [LEVEL_W-1:0] release_step;
    logic [LEVEL_W-1:0] sustain_floor;
    logic [LEVEL_W-1:0] stp_step;
    logic [LEVEL_W-1:0] stp_floor;
    logic               stp_dir;
    logic [LEVEL_W-1:0] stp_next;
    logic               stp_hit;
    logic [15:0]        product;
    logic               gate_on;
    logic               gate_off;

    assign attack_step   = rate_to_step(bus.attack_rate,  STEP_SH);
    assign decay_step    = rate_to_step(bus.decay_rate,   STEP_SH);
    assign release_step  = rate_to_step(bus.release_rate, STEP_SH);
    assign sustain_floor = {bus.sustain_lvl, 8'h00};

    // Scaling uses the level before this strobe's update (one-strobe lag).
    assign product = {8'd0, bus.osc_sample} * {8'd0, level_q[LEVEL_W-1 -: 8]};

    always_comb begin
        stp_step  = attack_step;
        stp_floor = '0;
        stp_dir   = DIR_UP;
        case (state_q)
            DECAY: begin
                stp_step  = decay_step;
                stp_floor = sustain_floor;
                stp_dir   = DIR_DOWN;
            end
            RELEASE: begin
                stp_step  = release_step;
                stp_floor = '0;
                stp_dir   = DIR_DOWN;
            end
            default: ;
        endcase
    end

    env_step u_step (
        .level      (level_q),
        .step       (stp_step),
        .floor      (stp_floor),
        .dir        (stp_dir),
        .next_level (stp_next),
        .hit        (stp_hit)
    );

    assign gate_on  = bus.gate  && ((state_q == IDLE) || (state_q == RELEASE));
    assign gate_off = !bus.gate && ((state_q == ATTACK) || (state_q == DECAY) ||
                                    (state_q == SUSTAIN));

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        sample_d    = sample_q;
        env_level_d = level_q[LEVEL_W-1 -: 8];
        if (!bus.en) begin
            state_d  = IDLE;
            level_d  = '0;
            sample_d = '0;
        end else begin
            if (bus.strobe) begin
                sample_d = product[15:8];
            end
            // A gate transition consumes the cycle; no level step alongside it.
            if (gate_on) begin
                state_d = ATTACK;
            end else if (gate_off) begin
                state_d = RELEASE;
            end else if (bus.strobe) begin
                case (state_q)
                    ATTACK: begin
                        level_d = stp_next;
                        if (stp_hit) begin
                            state_d = DECAY;
                        end
                    end
                    DECAY: begin
                        level_d = stp_next;
                        if (stp_hit) begin
                            state_d = SUSTAIN;
                        end
                    end
                    SUSTAIN: begin
                        level_d = sustain_floor;
                    end
                    RELEASE: begin
                        level_d = stp_next;
                        if (stp_hit) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        level_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            level_q     <= '0;
            sample_q    <= '0;
            env_level_q <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            sample_q    <= sample_d;
            env_level_q <= env_level_d;
        end
    end

    assign bus.sample    = sample_q;
    assign bus.env_level = env_level_q;
    assign bus.env_state = state_q;
    assign bus.active    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adsr_env.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adsr_env : phase table plus hand sequences, sample scoreboard on strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_adsr_env;
    import synth_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adsr_env_if bus();

    adsr_env #(.STEP_SH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int         m_level;
    env_state_t m_state;

    typedef struct {
        string      name;
        logic       gate;
        logic [7:0] ar;
        logic [7:0] dr;
        logic [7:0] sl;
        int         n_strobes;
        env_state_t exp_state;
        logic [15:0] exp_level;
        logic [7:0] exp_env;
        logic       exp_active;
        logic       chk_sample;
        logic [7:0] exp_sample;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input string nm, input logic g,
                                input logic [7:0] ar, input logic [7:0] dr,
                                input logic [7:0] sl, input int n,
                                input env_state_t s, input logic [15:0] lv,
                                input logic [7:0] env, input logic act,
                                input logic cs, input logic [7:0] es);
        vec_t v;
        v.name = nm; v.gate = g; v.ar = ar; v.dr = dr; v.sl = sl;
        v.n_strobes = n; v.exp_state = s; v.exp_level = lv; v.exp_env = env;
        v.exp_active = act; v.chk_sample = cs; v.exp_sample = es;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int rate_step(input logic [7:0] r);
        return (r == 8'd0) ? 65535 : int'(r) * 16;
    endfunction

    // Reference envelope in plain integer arithmetic, advanced once per clock.
    task automatic model_edge();
        int fl;
        if (!bus.en) begin
            m_state = IDLE;
            m_level = 0;
            return;
        end
        if ((m_state == IDLE || m_state == RELEASE) && bus.gate) begin
            m_state = ATTACK;
        end else if ((m_state == ATTACK || m_state == DECAY || m_state == SUSTAIN) && !bus.gate) begin
            m_state = RELEASE;
        end else if (bus.strobe) begin
            fl = int'(bus.sustain_lvl) * 256;
            case (m_state)
                ATTACK: begin
                    m_level = m_level + rate_step(bus.attack_rate);
                    if (m_level >= 65535) begin m_level = 65535; m_state = DECAY; end
                end
                DECAY: begin
                    m_level = m_level - rate_step(bus.decay_rate);
                    if (m_level <= fl) begin m_level = fl; m_state = SUSTAIN; end
                end
                SUSTAIN: m_level = fl;
                RELEASE: begin
                    m_level = m_level - rate_step(bus.release_rate);
                    if (m_level <= 0) begin m_level = 0; m_state = IDLE; end
                end
                default: m_level = 0;
            endcase
        end
    endtask

    task automatic cycle();
        logic pushed;
        pushed = 1'b0;
        if (bus.en && bus.strobe) begin
            exp_q.push_back(8'((int'(bus.osc_sample) * (m_level / 256)) / 256));
            pushed = 1'b1;
        end
        model_edge();
        @(posedge clk);
        #1;
        if (pushed) begin
            check("sample_sb", 32'(bus.sample), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic strobe_once();
        bus.strobe = 1'b1;
        cycle();
        bus.strobe = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        vecs[0]  = mk("atk255",  1'b1, 8'h10, 8'h20, 8'h80, 255, ATTACK,  16'hFF00, 8'hFF, 1'b1, 1'b0, 8'h00);
        vecs[1]  = mk("atk256",  1'b1, 8'h10, 8'h20, 8'h80, 1,   DECAY,   16'hFFFF, 8'hFF, 1'b1, 1'b0, 8'h00);
        vecs[2]  = mk("dec63",   1'b1, 8'h10, 8'h20, 8'h80, 63,  DECAY,   16'h81FF, 8'h81, 1'b1, 1'b0, 8'h00);
        vecs[3]  = mk("dec64",   1'b1, 8'h10, 8'h20, 8'h80, 1,   SUSTAIN, 16'h8000, 8'h80, 1'b1, 1'b0, 8'h00);
        vecs[4]  = mk("sus_smp", 1'b1, 8'h10, 8'h20, 8'h80, 1,   SUSTAIN, 16'h8000, 8'h80, 1'b1, 1'b1, 8'h7F);
        vecs[5]  = mk("rel_ent", 1'b0, 8'h10, 8'h20, 8'h80, 0,   RELEASE, 16'h8000, 8'h80, 1'b1, 1'b0, 8'h00);
        vecs[6]  = mk("rel8",    1'b0, 8'h10, 8'h20, 8'h80, 8,   RELEASE, 16'h0080, 8'h00, 1'b1, 1'b0, 8'h00);
        vecs[7]  = mk("rel9",    1'b0, 8'h10, 8'h20, 8'h80, 1,   IDLE,    16'h0000, 8'h00, 1'b0, 1'b0, 8'h00);
        vecs[8]  = mk("atk4000", 1'b1, 8'h40, 8'h20, 8'h80, 16,  ATTACK,  16'h4000, 8'h40, 1'b1, 1'b0, 8'h00);
        vecs[9]  = mk("atk0",    1'b1, 8'h00, 8'h00, 8'h80, 1,   DECAY,   16'hFFFF, 8'hFF, 1'b1, 1'b0, 8'h00);
        vecs[10] = mk("dec0",    1'b1, 8'h00, 8'h00, 8'h80, 1,   SUSTAIN, 16'h8000, 8'h80, 1'b1, 1'b0, 8'h00);
        vecs[11] = mk("sus_live",1'b1, 8'h00, 8'h00, 8'h40, 1,   SUSTAIN, 16'h4000, 8'h40, 1'b1, 1'b0, 8'h00);
        vecs[12] = mk("rel4000", 1'b0, 8'h00, 8'h00, 8'h40, 0,   RELEASE, 16'h4000, 8'h40, 1'b1, 1'b0, 8'h00);

        rst = 1'b1;
        bus.en = 1'b0; bus.gate = 1'b0; bus.strobe = 1'b0;
        bus.attack_rate = 8'h00; bus.decay_rate = 8'h00; bus.sustain_lvl = 8'h00;
        bus.release_rate = 8'h00; bus.osc_sample = 8'h00;
        m_state = IDLE; m_level = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.sample", 32'(bus.sample), 32'h0);
        check("rst.env",    32'(bus.env_level), 32'h0);
        check("rst.state",  32'(bus.env_state), 32'(IDLE));
        check("rst.active", 32'(bus.active), 32'h0);
        rst = 1'b0;

        bus.en = 1'b1; bus.release_rate = 8'hFF; bus.osc_sample = 8'hFF;
        for (int i = 0; i < 13; i++) begin
            bus.gate        = vecs[i].gate;
            bus.attack_rate = vecs[i].ar;
            bus.decay_rate  = vecs[i].dr;
            bus.sustain_lvl = vecs[i].sl;
            cycle();
            repeat (vecs[i].n_strobes) strobe_once();
            cycle();
            check($sformatf("%s.state", vecs[i].name), 32'(bus.env_state), 32'(vecs[i].exp_state));
            check($sformatf("%s.level", vecs[i].name), 32'(dut.level_q), 32'(vecs[i].exp_level));
            check($sformatf("%s.env", vecs[i].name), 32'(bus.env_level), 32'(vecs[i].exp_env));
            check($sformatf("%s.active", vecs[i].name), 32'(bus.active), 32'(vecs[i].exp_active));
            if (vecs[i].chk_sample) begin
                check($sformatf("%s.sample", vecs[i].name), 32'(bus.sample), 32'(vecs[i].exp_sample));
            end
        end

        // Retrigger from RELEASE on a strobe cycle: level kept, step deferred.
        bus.attack_rate = 8'h10;
        bus.gate = 1'b1;
        bus.strobe = 1'b1;
        cycle();
        bus.strobe = 1'b0;
        check("retrig.state", 32'(bus.env_state), 32'(ATTACK));
        check("retrig.level", 32'(dut.level_q), 32'h4000);
        repeat (3) cycle();
        strobe_once();
        check("retrig.step", 32'(dut.level_q), 32'h4100);

        // Disable mid-attack: idle next clock, strobes ignored.
        bus.en = 1'b0;
        cycle();
        check("dis.state",  32'(bus.env_state), 32'(IDLE));
        check("dis.level",  32'(dut.level_q), 32'h0);
        check("dis.sample", 32'(bus.sample), 32'h0);
        check("dis.active", 32'(bus.active), 32'h0);
        bus.strobe = 1'b1;
        cycle();
        bus.strobe = 1'b0;
        cycle();
        check("dis_strobe.state",  32'(bus.env_state), 32'(IDLE));
        check("dis_strobe.sample", 32'(bus.sample), 32'h0);
        check("dis_strobe.env",    32'(bus.env_level), 32'h0);

        // Full-scale product, then asynchronous reset between clock edges.
        bus.en = 1'b1; bus.attack_rate = 8'h00; bus.decay_rate = 8'h01; bus.sustain_lvl = 8'h00;
        cycle();
        strobe_once();
        strobe_once();
        check("fs.state",  32'(bus.env_state), 32'(DECAY));
        check("fs.level",  32'(dut.level_q), 32'hFFEF);
        check("fs.sample", 32'(bus.sample), 32'hFE);
        #2;
        rst = 1'b1;
        #1;
        check("arst.sample", 32'(bus.sample), 32'h0);
        check("arst.env",    32'(bus.env_level), 32'h0);
        check("arst.state",  32'(bus.env_state), 32'(IDLE));
        check("arst.active", 32'(bus.active), 32'h0);
        check("arst.level",  32'(dut.level_q), 32'h0);
        m_state = IDLE; m_level = 0;
        #2;
        rst = 1'b0;

        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
